// File: rtl/hazard_pkg.sv
// ============================================================================
//  Module  : hazard_pkg
//  Brief   : Shared encodings for the pipeline hazard controller.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } hzState_t;

   localparam logic [1:0] FWD_RF      = 2'b00;
   localparam logic [1:0] FWD_WB      = 2'b01;
   localparam logic [1:0] FWD_MEM     = 2'b10;
   localparam logic [1:0] RESULT_LOAD = 2'b01;

   // x0 is hardwired to zero, so it never produces a dependency.
   function automatic logic regMatch(input logic [4:0] rd, input logic [4:0] rs);
      return (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_sel.sv
// ============================================================================
//  Module  : fwd_sel
//  Brief   : Operand forwarding select for one Execute-stage source register.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_sel
   import hazard_pkg::*;
(
   input  logic [4:0] i_rs,
   input  logic [4:0] i_rdM,
   input  logic [4:0] i_rdW,
   input  logic       i_regWriteM,
   input  logic       i_regWriteW,
   output logic [1:0] o_fwd
);

   // Memory stage holds the younger result, so it wins over Writeback.
   always_comb begin
      o_fwd = FWD_RF;
      if (i_regWriteM && regMatch(i_rdM, i_rs)) begin
         o_fwd = FWD_MEM;
      end else if (i_regWriteW && regMatch(i_rdW, i_rs)) begin
         o_fwd = FWD_WB;
      end
   end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module  : hazard_ctrl
//  Brief   : Forwarding, stall/flush and data-memory wait sequencing for the
//            5-stage core. Optional performance counters: HAZARD_PERF_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int WAIT_W         = 8,
   parameter int CNT_W          = 32
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic [1:0] ResultSrcE,
   input  logic       PCSrcE,
   input  logic       MemReqM,
   input  logic       MemReadyM,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushW,
   output logic       MemTimeout
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0] LoadStallCnt,
   output logic [CNT_W-1:0] MemStallCnt,
   output logic [CNT_W-1:0] FlushCnt
`endif
);

   localparam logic [WAIT_W-1:0] c_waitLast = WAIT_W'(TIMEOUT_CYCLES - 1);

   generate
      if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2**WAIT_W - 1) || CNT_W < 1) begin : g_paramCheck
         $error("hazard_ctrl: TIMEOUT_CYCLES/WAIT_W/CNT_W out of range");
      end
   endgenerate

   hzState_t          r_state;
   hzState_t          w_nextState;
   logic [WAIT_W-1:0] r_waitCnt;
   logic [WAIT_W-1:0] w_waitCntNext;
   logic              r_memTimeout;
   logic              w_memStall;
   logic              w_lwStall;
   logic [1:0]        w_fwdA;
   logic [1:0]        w_fwdB;

   fwd_sel u_fwdA (
      .i_rs        (Rs1E),
      .i_rdM       (RdM),
      .i_rdW       (RdW),
      .i_regWriteM (RegWriteM),
      .i_regWriteW (RegWriteW),
      .o_fwd       (w_fwdA)
   );

   fwd_sel u_fwdB (
      .i_rs        (Rs2E),
      .i_rdM       (RdM),
      .i_rdW       (RdW),
      .i_regWriteM (RegWriteM),
      .i_regWriteW (RegWriteW),
      .o_fwd       (w_fwdB)
   );

   assign w_lwStall = (ResultSrcE == RESULT_LOAD) &&
                      (regMatch(RdE, Rs1D) || regMatch(RdE, Rs2D));

   // Wait sequencer: ready in the same cycle as the last allowed wait beats timeout.
   always_comb begin
      w_nextState   = r_state;
      w_waitCntNext = r_waitCnt;
      w_memStall    = 1'b0;
      case (r_state)
         RUN: begin
            w_memStall    = MemReqM && !MemReadyM;
            w_waitCntNext = '0;
            if (w_memStall) begin
               w_nextState = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            w_memStall = !MemReadyM;
            if (MemReadyM) begin
               w_nextState   = RUN;
               w_waitCntNext = '0;
            end else if (r_waitCnt == c_waitLast) begin
               w_nextState = FAULT;
            end else begin
               w_waitCntNext = r_waitCnt + 1'b1;
            end
         end
         FAULT: begin
            w_memStall = 1'b1;
         end
         default: begin
            w_nextState   = RUN;
            w_waitCntNext = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= RUN;
         r_waitCnt    <= '0;
         r_memTimeout <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_waitCnt <= w_waitCntNext;
         if (w_nextState == FAULT) begin
            r_memTimeout <= 1'b1;
         end
      end
   end

   // A memory stall freezes the whole pipe, so pending flushes wait for release.
   always_comb begin
      ForwardAE = w_fwdA;
      ForwardBE = w_fwdB;
      StallF    = w_lwStall;
      StallD    = w_lwStall;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = PCSrcE;
      FlushE    = w_lwStall || PCSrcE;
      FlushW    = 1'b0;
      if (reset) begin
         ForwardAE = FWD_RF;
         ForwardBE = FWD_RF;
         StallF    = 1'b0;
         StallD    = 1'b0;
         FlushD    = 1'b1;
         FlushE    = 1'b1;
         FlushW    = 1'b1;
      end else if (w_memStall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushD = 1'b0;
         FlushE = 1'b0;
         FlushW = 1'b1;
      end
   end

   assign MemTimeout = r_memTimeout;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] r_loadStallCnt;
   logic [CNT_W-1:0] r_memStallCnt;
   logic [CNT_W-1:0] r_flushCnt;

   // All counters saturate rather than wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_loadStallCnt <= '0;
         r_memStallCnt  <= '0;
         r_flushCnt     <= '0;
      end else begin
         if (w_lwStall && !w_memStall && (r_loadStallCnt != '1)) begin
            r_loadStallCnt <= r_loadStallCnt + 1'b1;
         end
         if (w_memStall && (r_memStallCnt != '1)) begin
            r_memStallCnt <= r_memStallCnt + 1'b1;
         end
         if (FlushD && (r_flushCnt != '1)) begin
            r_flushCnt <= r_flushCnt + 1'b1;
         end
      end
   end

   assign LoadStallCnt = r_loadStallCnt;
   assign MemStallCnt  = r_memStallCnt;
   assign FlushCnt     = r_flushCnt;
`endif

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core.
- Generates operand forwarding selects for the Execute stage.
- Generates stall/flush controls for the IF/ID, ID/IEx (the `clear` input of the ID/IEx control register), EX/MEM and MEM/WB registers.
- Sequences multi-cycle data-memory waits via a small FSM, with a timeout watchdog.

Parameters:
- TIMEOUT_CYCLES, 255, max consecutive cycles in MEM_WAIT before declaring a fault (1..2^WAIT_W-1).
- WAIT_W, 8, width of the wait counter.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Rs1D, Rs2D  in  5  source registers in Decode.
- Rs1E, Rs2E, RdE  in  5  sources/destination in Execute.
- RdM, RdW  in  5  destinations in Memory/Writeback.
- RegWriteM, RegWriteW  in  1  write enables in Memory/Writeback.
- ResultSrcE  in  2  result select in Execute; 2'b01 = load.
- PCSrcE  in  1  taken branch/jump resolved in Execute.
- MemReqM  in  1  load/store active in Memory.
- MemReadyM  in  1  data memory completes access this cycle.
- ForwardAE, ForwardBE  out  2  00 = regfile, 01 = Writeback result, 10 = Memory ALU result.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1  clear the corresponding pipeline register (bubble).
- MemTimeout  out  1  sticky fault flag.

Behaviour:
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E; else 01 if RegWriteW && RdW!=0 && RdW==Rs1E; else 00.
  - Memory stage has priority. ForwardBE is identical using Rs2E.
- lwStall = (ResultSrcE==01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FSM states: RUN, MEM_WAIT, FAULT. Reset → RUN; wait_cnt=0; MemTimeout=0.
- memStall (combinational):
  - RUN: MemReqM && !MemReadyM.
  - MEM_WAIT: !MemReadyM.
  - FAULT: 1.
- Transitions:
  - RUN → MEM_WAIT when memStall.
  - MEM_WAIT → RUN when MemReadyM.
  - MEM_WAIT → FAULT when wait_cnt==TIMEOUT_CYCLES-1 and !MemReadyM.
  - FAULT exits only via reset.
- wait_cnt: cleared on entering MEM_WAIT or RUN; +1 each MEM_WAIT cycle. MemReadyM wins over timeout in the same cycle.
- MemTimeout: set on entry to FAULT; held until reset.
- When memStall=1:
  - StallF=StallD=StallE=StallM=1, FlushW=1.
  - FlushD=FlushE=0; a pending PCSrcE/lwStall stays frozen in the pipe and takes effect on the release cycle.
- When memStall=0:
  - StallF=StallD=lwStall; StallE=StallM=FlushW=0.
  - FlushD=PCSrcE; FlushE=lwStall || PCSrcE.
  - lwStall together with PCSrcE: flush wins for E; F/D still stall for one cycle (harmless, since D is flushed).
- While reset=1: all Stall*=0, FlushD=FlushE=FlushW=1, Forward*=00.
- Reset mid-wait: returns to RUN next cycle; counters cleared.
- Latency: all controls are combinational from inputs and current state; zero-cycle.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - Adds outputs LoadStallCnt, MemStallCnt, FlushCnt (CNT_W each).
  - LoadStallCnt: +1 per cycle with lwStall && !memStall.
  - MemStallCnt: +1 per cycle with memStall.
  - FlushCnt: +1 per cycle with FlushD.
  - All saturate at all-ones; cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package hazard_pkg: FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, FAULT=2'd2); forwarding codes FWD_RF/FWD_WB/FWD_MEM; RESULT_LOAD=2'b01.
- One sub-module, fwd_sel: a pure combinational forwarding mux-select, instantiated once per operand (A, B).

Test Plan:
- RegWriteM=1, RdM=5, Rs1E=5, RegWriteW=1, RdW=5 → ForwardAE=10; set RdM=0 → ForwardAE=01.
- ResultSrcE=01, RdE=7, Rs2D=7 → StallF=StallD=1, FlushE=1 for one cycle; RdE=0 → no stall.
- PCSrcE=1, no mem stall → FlushD=FlushE=1, StallF=0.
- MemReqM=1, MemReadyM low for 3 cycles then high → all Stall*=1, FlushW=1 for 3 cycles, FSM back to RUN on the 4th; PCSrcE asserted during the wait → FlushD/FlushE only on the release cycle.
- TIMEOUT_CYCLES=4, MemReadyM held low → FAULT after 4 wait cycles, MemTimeout=1, stalls persist; assert reset for 1 cycle → RUN, MemTimeout=0.
- HAZARD_PERF_EN: 2 load-use stalls + 3 mem-wait cycles → LoadStallCnt=2, MemStallCnt=3.
